// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/grant and memory bus bundle for mem_arbiter
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 : requester commands (byte address)
//   gnt0/gnt1, rvalid0/rvalid1, rdata0/rdata1       : grant and read response per port
//   mem_en, mem_we, mem_addr, mem_wdata, mem_rdata  : single-port data memory
//   busy, oob                                        : arbiter status
//   slave modport = arbiter side, master modport = requesters plus memory side
interface mem_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int SIZE = 64
);
  localparam int AW = $clog2(SIZE);
  logic req0, req1, we0, we1;
  logic [WIDTH-1:0] addr0, addr1, wdata0, wdata1;
  logic gnt0, gnt1, rvalid0, rvalid1;
  logic [WIDTH-1:0] rdata0, rdata1;
  logic mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata, mem_rdata;
  logic busy, oob;
  modport slave (
    input req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    output mem_en, mem_we, mem_addr, mem_wdata, busy, oob
  );
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    input mem_en, mem_we, mem_addr, mem_wdata, busy, oob
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single-port data memory
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mem_arbiter_if.slave (requests, grants, read responses, memory bus, busy/oob)
//   ARB_FIXED_PRIO_EN defined : port 0 always wins a tie, no priority pointer
//   ARB_FIXED_PRIO_EN undefined: round-robin tie-break via prio
module mem_arbiter #(
  parameter int WIDTH = 32,
  parameter int SIZE = 64
) (
  input logic clk,
  input logic rst_n,
  mem_arbiter_if.slave bus
);
  localparam int AW = $clog2(SIZE);
  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(SIZE);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state, state_nx;
  logic we_q, owner_q, pick1, take, oor;
  logic [WIDTH-3:0] word_q;
  logic [WIDTH-1:0] wdata_q, rdata0_q, rdata1_q, rd;
`ifdef ARB_FIXED_PRIO_EN
  assign pick1 = bus.req1 & ~bus.req0;
`else
  logic prio;
  // prio names the port that wins the next tie
  assign pick1 = bus.req1 & (~bus.req0 | prio);
`endif
  // gnt is gated by rst_n so every output reads 0 while reset is held
  assign take = (state == IDLE) & (bus.req0 | bus.req1) & rst_n;
  assign oor = {2'b00, word_q} >= LIMIT;
  assign rd = oor ? '0 : bus.mem_rdata;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = take ? ISSUE : IDLE;
    else if (state == ISSUE) state_nx = we_q ? IDLE : RESP;
    else state_nx = IDLE;
  end
  assign bus.gnt0 = take & ~pick1;
  assign bus.gnt1 = take & pick1;
  assign bus.mem_en = state == ISSUE;
  assign bus.mem_we = bus.mem_en & we_q & ~oor;
  assign bus.mem_addr = word_q[AW-1:0];
  assign bus.mem_wdata = wdata_q;
  assign bus.busy = state != IDLE;
  assign bus.oob = bus.mem_en & oor;
  assign bus.rvalid0 = (state == RESP) & ~owner_q;
  assign bus.rvalid1 = (state == RESP) & owner_q;
  // the owner sees memory data live in RESP; otherwise each port keeps its last response
  assign bus.rdata0 = bus.rvalid0 ? rd : rdata0_q;
  assign bus.rdata1 = bus.rvalid1 ? rd : rdata1_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      we_q <= 1'b0;
      owner_q <= 1'b0;
      word_q <= '0;
      wdata_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifndef ARB_FIXED_PRIO_EN
      prio <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (take) begin
        we_q <= pick1 ? bus.we1 : bus.we0;
        word_q <= pick1 ? bus.addr1[WIDTH-1:2] : bus.addr0[WIDTH-1:2];
        wdata_q <= pick1 ? bus.wdata1 : bus.wdata0;
        owner_q <= pick1;
`ifndef ARB_FIXED_PRIO_EN
        prio <= ~pick1;
`endif
      end
      if (bus.rvalid0) rdata0_q <= rd;
      if (bus.rvalid1) rdata1_q <= rd;
    end
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port data memory between the core's load/store port (port 0) and an auxiliary requester (port 1, program loader / debug / DMA). It sits between the processor top and the data memory and serializes requests through a request/grant handshake. Grants use round-robin fairness, and read data is returned to the winning port with a valid pulse. Byte addresses are translated to memory word indices, and accesses outside the memory are flagged.

## Interface
- WIDTH, 32, data and byte-address width
- SIZE, 64, memory depth in words; AW = $clog2(SIZE)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req0 / req1  in  1  request from port 0 / port 1
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  WIDTH  byte address; bits [1:0] ignored
- wdata0 / wdata1  in  WIDTH  write data
- gnt0 / gnt1  out  1  command accepted this cycle (combinational)
- rvalid0 / rvalid1  out  1  read data valid, one-cycle pulse
- rdata0 / rdata1  out  WIDTH  read data, valid when rvalid is high
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  word index
- mem_wdata  out  WIDTH  write data to memory
- mem_rdata  in  WIDTH  memory read data, one-cycle synchronous latency after mem_en
- busy  out  1  high whenever state != IDLE
- oob  out  1  one-cycle pulse: the current access is out of range

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If no req, stay in IDLE.
  - Otherwise pick the winner: a sole requester wins. If both request, the port named by the priority pointer `prio` wins.
  - Assert gnt for the winner only, combinationally in this cycle.
  - On the clock edge, latch we, addr, wdata and owner, flip `prio` to the other port, and go to ISSUE.
- Requester rule: hold req, we, addr and wdata stable until it samples gnt high. It may drop or change them in the following cycle.
- ISSUE:
  - Drive mem_en=1, mem_addr = latched addr[AW+1:2], mem_wdata = latched wdata.
  - Drive mem_we = latched we & ~out_of_range.
  - A write returns to IDLE. A read goes to RESP.
- RESP:
  - Assert rvalid for the owner only.
  - rdata_owner = mem_rdata, or 0 if the access was out of range.
  - Return to IDLE.
- Out of range: the word index addr[WIDTH-1:2] is >= SIZE. oob pulses during ISSUE. Writes are suppressed; reads return 0.
- rdata of the non-owner port holds its last value. Only rvalid is meaningful.
- A request asserted during ISSUE or RESP is not granted. It waits in IDLE for arbitration.

## Timing
- Reset values: state=IDLE, prio=port 0, gnt*=0, rvalid*=0, rdata*=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, oob=0. All latched command registers are cleared.
- Write: gnt in cycle N, memory write in cycle N+1. Next gnt possible in cycle N+2.
- Read: gnt in cycle N, mem_en in N+1, rvalid in N+2. Next gnt possible in cycle N+3.
- mem_en and mem_we are high only in ISSUE. rvalid is high only in RESP.
- Back-to-back requests from both ports alternate strictly: 0,1,0,1…
- Reset asserted mid-transaction: the transaction is abandoned at once. A write not yet in ISSUE is never performed. A pending read produces no rvalid. All outputs return to their reset values asynchronously.
- Simultaneous req0 and req1 on the first cycle after reset: port 0 wins.

## Configuration
- ARB_FIXED_PRIO_EN defined: port 0 always wins when both request. The `prio` register is removed, and port 1 can starve under continuous port-0 traffic.
- ARB_FIXED_PRIO_EN undefined (default): round-robin as described above.

## Test plan
- Port 0 writes wdata=7 to addr=100: gnt0 in cycle N, then mem_en=1, mem_we=1, mem_addr=25, mem_wdata=7 in N+1, then busy=0 in N+2.
- Port 1 reads addr=100 with the memory model holding 7: rvalid1=1 and rdata1=7 exactly 2 cycles after gnt1, and rvalid0 stays 0.
- Both ports hold reads continuously for 8 transactions: grants alternate 0,1,0,1…, each port receives 4 rvalids, and port 0 wins the first.
- Port 0 writes to addr=256 (word 64 with SIZE=64): oob=1 and mem_we=0 in ISSUE. A following read from 256 returns rdata0=0 with oob=1.
- Reset driven low during ISSUE of a port-1 read: no rvalid1. All outputs are 0 while reset is low, and the first arbitration after reset favours port 0.
- With ARB_FIXED_PRIO_EN: req0 and req1 both held for 6 transactions, so gnt1 never asserts. Dropping req0 lets gnt1 assert in the next IDLE cycle.
